// File: rtl/alu_exec_ctrl_if.sv
// Bundle for alu_exec_ctrl: the instruction handshake, the ALU drive and capture
// signals, and the status outputs.
interface alu_exec_ctrl_if;
   logic [18:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_opcode;
   logic [1:0]  alu_mode;
   logic [31:0] alu_out;
   logic        alu_eq;
   logic        done;
   logic        eq_flag;
   logic        za;
   logic        zb;
   logic        busy;

   modport master (
      output instr, instr_valid, alu_out, alu_eq,
      input  instr_ready, alu_a, alu_b, alu_opcode, alu_mode,
             done, eq_flag, za, zb, busy
   );

   modport slave (
      input  instr, instr_valid, alu_out, alu_eq,
      output instr_ready, alu_a, alu_b, alu_opcode, alu_mode,
             done, eq_flag, za, zb, busy
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: reads operands from a 16-entry register file, drives
// the ALU, captures its result and writes it back (optionally as a wide pair).
//
//   state  | meaning
//   S_IDLE | waiting for an instruction, instr_ready high
//   S_READ | load ALU operands, opcode/mode and zero flags
//   S_EXEC | ALU settles; capture result and eq
//   S_WB   | register write(s); done pulses after this cycle
module alu_exec_ctrl #(
   parameter int NREGS = 16,
   parameter int DW    = 16
) (
   input logic           clk,
   input logic           rst,
   alu_exec_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t            state_q, state_d;
   logic [18:0]       instr_q, instr_d;
   logic [DW-1:0]     regs_q [NREGS];
   logic [DW-1:0]     regs_d [NREGS];
   logic [DW-1:0]     alu_a_q, alu_a_d;
   logic [DW-1:0]     alu_b_q, alu_b_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [1:0]        mode_q, mode_d;
   logic [2*DW-1:0]   result_q, result_d;
   logic              eq_q, eq_d;
   logic              za_q, za_d;
   logic              zb_q, zb_d;
   logic              done_q, done_d;

   logic [3:0]        rd, rd_nx, rs1, rs2;
   logic              li, wide;

   assign rd    = instr_q[13:10];
   assign rs1   = instr_q[9:6];
   assign rs2   = instr_q[5:2];
   assign li    = instr_q[1];
   assign wide  = instr_q[0];
   assign rd_nx = rd + 4'd1;

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      regs_d   = regs_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      opcode_d = opcode_q;
      mode_d   = mode_q;
      result_d = result_q;
      eq_d     = eq_q;
      za_d     = za_q;
      zb_d     = zb_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               state_d = bus.instr[1] ? S_WB : S_READ;
            end
         end
         S_READ: begin
            alu_a_d  = regs_q[rs1];
            alu_b_d  = regs_q[rs2];
            opcode_d = instr_q[16:14];
            mode_d   = instr_q[18:17];
            za_d     = (regs_q[rs1] == '0);
            zb_d     = (regs_q[rs2] == '0);
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            result_d = bus.alu_out;
            eq_d     = bus.alu_eq;
            state_d  = S_WB;
         end
         S_WB: begin
            done_d = 1'b1;
            if (li) begin
               regs_d[rd] = {{(DW-8){1'b0}}, instr_q[9:2]};
            end else begin
               regs_d[rd] = result_q[DW-1:0];
               // rd=15 with wide wraps the upper half into R0
               if (wide) regs_d[rd_nx] = result_q[2*DW-1:DW];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         opcode_q <= '0;
         mode_q   <= '0;
         result_q <= '0;
         eq_q     <= 1'b0;
         za_q     <= 1'b0;
         zb_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         regs_q   <= regs_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         opcode_q <= opcode_d;
         mode_q   <= mode_d;
         result_q <= result_d;
         eq_q     <= eq_d;
         za_q     <= za_d;
         zb_q     <= zb_d;
         done_q   <= done_d;
      end
   end

   assign bus.instr_ready = (state_q == S_IDLE) && !rst;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_opcode  = opcode_q;
   assign bus.alu_mode    = mode_q;
   assign bus.done        = done_q;
   assign bus.eq_flag     = eq_q;
   assign bus.za          = za_q;
   assign bus.zb          = zb_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed scenarios plus random instructions,
// checked against an array-based reference model at every done pulse.
module tb_alu_exec_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_exec_ctrl_if bus ();

   alu_exec_ctrl #(.NREGS(16), .DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Bench ALU: returns {eq, out}
   function automatic logic [32:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op, input logic [1:0] mode);
      logic [31:0] o;
      logic        e;
      case (op)
         3'd0: o = {16'h0, a + b};
         3'd1: o = {16'h0, a - b};
         3'd2: o = a * b;
         3'd3: o = {a, b};
         3'd4: o = {16'h0, a ^ b};
         3'd5: o = {b, a};
         3'd6: o = {a & b, a | b};
         default: o = 32'hDEAD_BEEF;
      endcase
      if (mode == 2'b01) o = ~o;
      e = (mode == 2'b11) ? 1'b1 : (a == b);
      return {e, o};
   endfunction

   assign {bus.alu_eq, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_mode);

   typedef struct {
      logic [15:0] a, b;
      logic [4:0]  opm;
      logic [2:0]  flags;
      int          done_edge;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_acc = 0;
   int          last_gap = 0;

   logic [15:0] mregs [16];
   logic [15:0] m_a, m_b;
   logic [2:0]  m_op;
   logic [1:0]  m_mode;
   logic        m_za, m_zb, m_eq;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      m_a = '0; m_b = '0; m_op = '0; m_mode = '0;
      m_za = 1'b0; m_zb = 1'b0; m_eq = 1'b0;
   endtask

   function automatic logic [18:0] mk_li(input logic [3:0] rd, input logic [7:0] imm);
      return {2'b00, 3'b000, rd, imm, 1'b1, 1'b0};
   endfunction

   function automatic logic [18:0] mk_alu(input logic [1:0] mode, input logic [2:0] op,
                                          input logic [3:0] rd, input logic [3:0] rs1,
                                          input logic [3:0] rs2, input logic wide);
      return {mode, op, rd, rs1, rs2, 1'b0, wide};
   endfunction

   // Present ins with valid held; b2b means the previous issue left valid high.
   task automatic issue(input logic [18:0] ins, input bit b2b, input int chk_a = -1,
                        input int chk_b = -1, input int chk_f = -1, input bit track = 1'b1);
      exp_t        e;
      int          waited;
      int          acc;
      logic [32:0] r;
      logic [3:0]  rd;
      @(negedge clk);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      waited = 0;
      while (!bus.instr_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.instr_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         bus.instr_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      if (b2b) check("issue_gap", 64'(acc - last_acc), 64'(last_gap));
      if (track) begin
         rd = ins[13:10];
         if (ins[1]) begin
            mregs[rd] = {8'h00, ins[9:2]};
         end else begin
            m_a    = mregs[ins[9:6]];
            m_b    = mregs[ins[5:2]];
            m_op   = ins[16:14];
            m_mode = ins[18:17];
            m_za   = (m_a == 0);
            m_zb   = (m_b == 0);
            r      = alu_fn(m_a, m_b, m_op, m_mode);
            m_eq   = r[32];
            mregs[rd] = r[15:0];
            if (ins[0]) mregs[(rd + 1) % 16] = r[31:16];
         end
         e.a         = (chk_a >= 0) ? 16'(chk_a) : m_a;
         e.b         = (chk_b >= 0) ? 16'(chk_b) : m_b;
         e.opm       = {m_op, m_mode};
         e.flags     = (chk_f >= 0) ? 3'(chk_f) : {m_za, m_zb, m_eq};
         e.done_edge = acc + (ins[1] ? 1 : 3);
         sb.push_back(e);
      end
      last_acc = acc;
      last_gap = ins[1] ? 2 : 4;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_edge", 64'(cyc), 64'(e.done_edge));
            check("alu_a", 64'(bus.alu_a), 64'(e.a));
            check("alu_b", 64'(bus.alu_b), 64'(e.b));
            check("opcode_mode", 64'({bus.alu_opcode, bus.alu_mode}), 64'(e.opm));
            check("za_zb_eq", 64'({bus.za, bus.zb, bus.eq_flag}), 64'(e.flags));
         end
      end
   end

   initial begin
      rst             = 1'b1;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("ready_in_reset", 64'(bus.instr_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", 64'(bus.instr_ready), 64'd1);
      check("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
      check("reset_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_mode}), 64'd0);
      check("reset_flags", 64'({bus.za, bus.zb, bus.eq_flag}), 64'd0);

      // LI then add, held valid throughout
      issue(mk_li(4'd1, 8'h05), 1'b0);
      issue(mk_li(4'd2, 8'h07), 1'b1);
      issue(mk_alu(2'b00, 3'd0, 4'd3, 4'd1, 4'd2, 1'b0), 1'b1, 16'h0005, 16'h0007);
      issue(mk_alu(2'b00, 3'd0, 4'd5, 4'd3, 4'd0, 1'b0), 1'b1, 16'h000C, 16'h0000);

      // wide write from rd=15 wraps into r0
      issue(mk_alu(2'b00, 3'd7, 4'd15, 4'd0, 4'd0, 1'b1), 1'b1);
      issue(mk_alu(2'b00, 3'd0, 4'd5, 4'd15, 4'd0, 1'b0), 1'b1, 16'hBEEF, 16'hDEAD);

      // zero/eq flags, then LI leaves flags and ALU drive alone
      idle(1);
      issue(mk_alu(2'b11, 3'd0, 4'd6, 4'd4, 4'd2, 1'b0), 1'b0, 16'h0000, 16'h0007, 3'b101);
      issue(mk_li(4'd9, 8'h3C), 1'b1, 16'h0000, 16'h0007, 3'b101);
      issue(mk_alu(2'b00, 3'd0, 4'd7, 4'd9, 4'd0, 1'b0), 1'b1, 16'h003C, 16'hDEAD);

      // rd == rs1
      idle(2);
      issue(mk_li(4'd1, 8'h05), 1'b0);
      issue(mk_alu(2'b00, 3'd0, 4'd1, 4'd1, 4'd2, 1'b0), 1'b1, 16'h0005, 16'h0007);
      issue(mk_alu(2'b00, 3'd0, 4'd8, 4'd1, 4'd0, 1'b0), 1'b1, 16'h000C, 16'hDEAD);

      // reset held for two cycles while an ALU instruction sits in EXEC
      idle(1);
      issue(mk_alu(2'b00, 3'd0, 4'd1, 4'd1, 4'd2, 1'b1), 1'b0, -1, -1, -1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      #1 check("ready_during_rst", 64'(bus.instr_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("ready_after_rst", 64'(bus.instr_ready), 64'd1);
      check("busy_after_rst", 64'(bus.busy), 64'd0);
      check("flags_after_rst", 64'({bus.za, bus.zb, bus.eq_flag, bus.alu_a}), 64'd0);
      for (int i = 0; i < 16; i += 2)
         issue(mk_alu(2'b00, 3'd3, 4'(i), 4'(i), 4'(i + 1), 1'b0), i != 0, 0, 0);

      // random traffic
      for (int n = 0; n < 80; n++) begin
         logic [18:0] ins;
         bit          b2b;
         ins    = 19'($urandom);
         ins[1] = ($urandom_range(0, 2) == 0);
         b2b    = ($urandom_range(0, 1) == 1) && (n != 0);
         if (!b2b) idle($urandom_range(0, 2));
         issue(ins, b2b);
      end
      // read back every register through the ALU
      idle(1);
      for (int i = 0; i < 16; i++)
         issue(mk_alu(2'b00, 3'd3, 4'd0, 4'(i), 4'((i + 5) % 16), 1'b0), i != 0);

      idle(1);
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
